// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared wishbone widths, select constant and copy FSM states
package wb_pkg;

    localparam int WB_ADR_W = 30;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    localparam logic [WB_SEL_W-1:0] SEL_ALL = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        GAP,
        FIN
    } wb_state_t;

endpackage

// File: rtl/wb_ack_timer.sv
// rtl/wb_ack_timer.sv - ack wait counter shared by wishbone masters
module wb_ack_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // expired flags the cycle whose edge would complete TIMEOUT waiting cycles
    assign expired = run && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_copy_master.sv
// rtl/wb_copy_master.sv - wishbone master copying len words from src to dst
module wb_copy_master
    import wb_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                start,
    input  logic [WB_ADR_W-1:0] src_adr,
    input  logic [WB_ADR_W-1:0] dst_adr,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WB_ADR_W-1:0] wishbone_adr_o,
    output logic [WB_DAT_W-1:0] wishbone_dat_o,
    input  logic [WB_DAT_W-1:0] wishbone_dat_i,
    output logic [WB_SEL_W-1:0] wishbone_sel_o,
    output logic                wishbone_we_o,
    output logic                wishbone_cyc_o,
    output logic                wishbone_stb_o,
    input  logic                wishbone_ack_i
);

    wb_state_t             state_q, state_d;
    logic [WB_ADR_W-1:0]   src_q, src_d;
    logic [WB_ADR_W-1:0]   dst_q, dst_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      idx_q, idx_d;
    logic [WB_DAT_W-1:0]   rbuf_q, rbuf_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [WB_ADR_W-1:0]   adr_q, adr_d;
    logic [WB_DAT_W-1:0]   dat_q, dat_d;
    logic [WB_SEL_W-1:0]   sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  timer_clear;
    logic                  timer_expired;
    logic                  last_word;

    assign last_word = (idx_q == len_q - LEN_W'(1));

    wb_ack_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (16)
    ) u_ack_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (timer_clear),
        .run       (stb_q && !wishbone_ack_i),
        .expired   (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        idx_d       = idx_q;
        rbuf_d      = rbuf_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        timer_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    src_d  = src_adr;
                    dst_d  = dst_adr;
                    len_d  = len;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (len == '0) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // strobe is low here only on the first word, right after start
                if (!stb_q) begin
                    stb_d       = 1'b1;
                    we_d        = 1'b0;
                    adr_d       = src_q + WB_ADR_W'(idx_q);
                    timer_clear = 1'b1;
                end else if (wishbone_ack_i) begin
                    rbuf_d  = wishbone_dat_i;
                    stb_d   = 1'b0;
                    state_d = WRITE;
                end else if (timer_expired) begin
                    stb_d   = 1'b0;
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            WRITE: begin
                // the strobe-low first cycle is the idle slot between read and write
                if (!stb_q) begin
                    stb_d       = 1'b1;
                    we_d        = 1'b1;
                    adr_d       = dst_q + WB_ADR_W'(idx_q);
                    dat_d       = rbuf_q;
                    timer_clear = 1'b1;
                end else if (wishbone_ack_i) begin
                    stb_d = 1'b0;
                    if (last_word) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        state_d = GAP;
                    end
                end else if (timer_expired) begin
                    stb_d   = 1'b0;
                    state_d = FIN;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            GAP: begin
                stb_d       = 1'b1;
                we_d        = 1'b0;
                adr_d       = src_q + WB_ADR_W'(idx_q);
                timer_clear = 1'b1;
                state_d     = READ;
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                stb_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        sel_d = stb_d ? SEL_ALL : '0;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rbuf_q  <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rbuf_q  <= rbuf_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign wishbone_adr_o = adr_q;
    assign wishbone_dat_o = dat_q;
    assign wishbone_sel_o = sel_q;
    assign wishbone_we_o  = we_q;
    assign wishbone_cyc_o = stb_q;
    assign wishbone_stb_o = stb_q;

endmodule
